dmem_dma_engine: RTL
====================

// Module: dmem_dma_engine
// PURPOSE
//  Bus initiator for the RISC16 data-memory port: copies or fills blocks of 16-bit words without CPU load/store traffic.
//  Drives mem_access_addr/mem_write_data/mem_write_en/mem_read toward the data memory and samples its combinational mem_read_data.
//  Sits beside the CPU datapath; an arbiter outside this block grants the memory port while busy=1.
// PARAMETERS
//  ADDR_W   16  memory address width; pointers wrap modulo 2^ADDR_W
//  DATA_W   16  memory word width
//  LEN_W    16  transfer-length counter width
// PORTS
//  clk              in   1       single clock, all state updates on posedge
//  rst              in   1       synchronous reset, active-high
//  start            in   1       1-cycle request; accepted only when busy=0
//  mode             in   1       0=COPY src->dst, 1=FILL dst with fill_data
//  src_addr         in   ADDR_W  COPY source start address
//  dst_addr         in   ADDR_W  destination start address
//  len              in   LEN_W   word count
//  fill_data        in   DATA_W  FILL pattern
//  abort            in   1       terminate transfer early
//  busy             out  1       transfer in progress (RD/WR/DONE)
//  done             out  1       1-cycle pulse at completion or abort
//  words_done       out  LEN_W   words written so far in current/last transfer
//  mem_access_addr  out  ADDR_W  memory address
//  mem_write_data   out  DATA_W  memory write data
//  mem_write_en     out  1       memory write strobe, committed at posedge
//  mem_read         out  1       memory read enable
//  mem_read_data    in   DATA_W  memory read data, combinational, valid while mem_read=1
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; pointers, count, buffer cleared. Reset wins over start/abort.
//  - FSM: IDLE -> (start & len!=0) COPY:RD / FILL:WR; IDLE -> (start & len==0) DONE.
//    RD -> WR always. WR -> RD (COPY, words remaining) | WR (FILL, remaining) | DONE (last word). DONE -> IDLE.
//  - Outputs are decoded from the current state only:
//    - RD: mem_read=1, addr=src_ptr; buffer <= mem_read_data at the posedge.
//    - WR: mem_write_en=1, addr=dst_ptr, data=buffer (COPY) or fill_data_q (FILL).
//    - Other states: addr/data/strobes are 0.
//  - All request fields are latched when start is accepted; later input changes have no effect.
//  - start while busy=1 is ignored; no queueing.
//  - Pointers +1 after each RD/WR, wrapping 2^ADDR_W-1 -> 0. words_done +1 per committed write.
//  - words_done holds its value until the next accepted start, then clears to 0.
//  - Throughput: COPY 2 cycles/word, FILL 1 cycle/word.
//    busy stays high 2N+1 (COPY) or N+1 (FILL) cycles after acceptance; done coincides with the final busy cycle.
//  - abort in RD/WR: that cycle's write is suppressed (mem_write_en = WR & ~abort); next state DONE.
//    words_done reflects only committed writes. abort in IDLE/DONE is ignored.
//  - Overlapping src/dst ranges are copied in ascending order; no overlap correction.
//  - Never asserts mem_read and mem_write_en in the same cycle.
// CONFIGURATION
//  DMEM_DMA_CHECKSUM_EN defined:
//    - Adds output checksum[DATA_W-1:0] = mod-2^DATA_W sum of every committed write word.
//    - Cleared on accepted start; valid and stable from done until the next start.
//  Undefined: no checksum port and no adder; all other behaviour identical.
// STRUCTURE
//  - Shared package/header dmem_dma_pkg: state encodings (IDLE, RD, WR, DONE), MODE_COPY=0 / MODE_FILL=1, default widths.
//  - One sub-module: dmem_dma_ptr, a loadable wrapping address counter instantiated twice (src_ptr, dst_ptr).
//  - FSM, length counter and buffer live in the top module.
// TESTING
//  - COPY src=0 dst=4 len=3, mem[0..2]=A1,B2,C3:
//    mem[4..6]=A1,B2,C3; busy 7 cycles; done once; words_done=3; reads never overlap writes.
//  - FILL dst=2 len=4 fill=BEEF: mem[2..5]=BEEF; busy 5 cycles; mem_read stays 0 throughout.
//  - len=0: busy 1 cycle with done; no mem_read or mem_write_en pulse; memory unchanged.
//  - COPY len=4, abort during the 2nd WR: only 1 word written; words_done=1; done next cycle; IDLE after.
//  - start with new args while busy, then src=FFFF dst=0010 len=2:
//    busy-time start ignored; reads at FFFF then 0000 (wrap).
//  - DMEM_DMA_CHECKSUM_EN build, FILL len=3 fill=8001: checksum=8003. rst mid-transfer: all outputs 0 next cycle.

Source files
------------

// File: rtl/dmem_dma_pkg.sv
// Shared encodings and default widths for the RISC16 data-memory DMA engine.
package dmem_dma_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dmem_dma_ptr.sv
// Loadable address counter that wraps modulo 2^ADDR_W; used for the source and
// destination pointers of the DMA engine.
module dmem_dma_ptr
  import dmem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dmem_dma_engine.sv
// Block copy/fill initiator for the RISC16 data-memory port.
// Optional build macro DMEM_DMA_CHECKSUM_EN adds a running sum of committed write words.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; memory port outputs all zero
// ST_RD   | COPY only: read src_ptr, capture word into buffer
// ST_WR   | write buffer (COPY) or fill pattern (FILL) to dst_ptr
// ST_DONE | one-cycle completion/abort pulse, then back to idle
module dmem_dma_engine
  import dmem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  dma_state_e        state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  words_q, words_d;

  logic              accept;
  logic              wr_commit;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;

  assign accept    = (state_q == ST_IDLE) && start;
  assign wr_commit = (state_q == ST_WR) && !abort;

  dmem_dma_ptr #(.ADDR_W(ADDR_W)) u_src_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (src_addr),
    .inc      (state_q == ST_RD),
    .ptr      (src_ptr)
  );

  dmem_dma_ptr #(.ADDR_W(ADDR_W)) u_dst_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (dst_addr),
    .inc      (state_q == ST_WR),
    .ptr      (dst_ptr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)               state_d = ST_DONE;
          else if (mode == MODE_FILL)  state_d = ST_WR;
          else                         state_d = ST_RD;
        end
      end
      ST_RD: state_d = abort ? ST_DONE : ST_WR;
      ST_WR: begin
        if (abort || remain_q == LEN_ONE) state_d = ST_DONE;
        else if (mode_q == MODE_FILL)     state_d = ST_WR;
        else                              state_d = ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-port outputs depend on state only, apart from abort gating the write strobe.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (state_q)
      ST_RD: begin
        mem_read        = 1'b1;
        mem_access_addr = src_ptr;
      end
      ST_WR: begin
        mem_write_en    = !abort;
        mem_access_addr = dst_ptr;
        mem_write_data  = (mode_q == MODE_FILL) ? fill_q : buf_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    fill_d   = fill_q;
    remain_d = remain_q;
    buf_d    = buf_q;
    words_d  = words_q;
    if (accept) begin
      mode_d   = mode;
      fill_d   = fill_data;
      remain_d = len;
      words_d  = '0;
    end
    if (state_q == ST_RD) buf_d = mem_read_data;
    if (state_q == ST_WR) remain_d = remain_q - LEN_ONE;
    if (wr_commit)        words_d = words_q + LEN_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COPY;
      fill_q   <= '0;
      remain_q <= '0;
      buf_q    <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      remain_q <= remain_d;
      buf_q    <= buf_d;
      words_q  <= words_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign words_done = words_q;

`ifdef DMEM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept)         csum_d = '0;
    else if (wr_commit) csum_d = csum_q + mem_write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule
